// File: rtl/snake_body_updater.sv
// rtl/snake_body_updater.sv - shifts the snake tail memory by one slot per game step
// and reports whether the new head lands on the updated body.
module snake_body_updater #(
  parameter int WORD_W    = 12,
  parameter int ADDR_W    = 7,
  parameter int MAX_TAILS = 127
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              grow,
  input  logic [WORD_W-1:0] cur_head_pos,
  input  logic [WORD_W-1:0] new_head_pos,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] num_tails,
  output logic              busy,
  output logic              done,
  output logic              collision
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, HEAD, FIN} state_t;

  localparam logic [ADDR_W-1:0] MAX_K = ADDR_W'(MAX_TAILS);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] tails_q;
  logic [ADDR_W-1:0] k_q;
  logic [ADDR_W-1:0] idx_q;
  logic [WORD_W-1:0] cur_q;
  logic [WORD_W-1:0] new_q;
  logic              coll_q;
  logic [ADDR_W-1:0] k_calc;
  logic [ADDR_W-1:0] s_calc;

  // Growth saturates at MAX_TAILS: the oldest tail simply falls off the end.
  always_comb begin
    k_calc = tails_q;
    if (grow && (tails_q < MAX_K)) begin
      k_calc = tails_q + ONE;
    end
    s_calc = (k_calc != '0) ? (k_calc - ONE) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tick) begin
          if (s_calc != '0) begin
            state_next = READ;
          end else if (k_calc != '0) begin
            state_next = HEAD;
          end else begin
            state_next = FIN;
          end
        end
      end
      READ:    state_next = WRITE;
      WRITE:   state_next = (idx_q != '0) ? READ : HEAD;
      HEAD:    state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tails_q <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      new_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            cur_q  <= cur_head_pos;
            new_q  <= new_head_pos;
            k_q    <= k_calc;
            idx_q  <= (s_calc != '0) ? (s_calc - ONE) : '0;
            coll_q <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_rdata == new_q) begin
            coll_q <= 1'b1;
          end
          if (idx_q != '0) begin
            idx_q <= idx_q - ONE;
          end
        end
        HEAD: begin
          if (cur_q == new_q) begin
            coll_q <= 1'b1;
          end
        end
        FIN: begin
          tails_q <= k_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Memory outputs are forced quiet while reset is held so an aborted update stops at once.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        READ: begin
          mem_addr = idx_q;
        end
        WRITE: begin
          mem_addr  = idx_q + ONE;
          mem_we    = 1'b1;
          mem_wdata = mem_rdata;
        end
        HEAD: begin
          mem_we    = 1'b1;
          mem_wdata = cur_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign num_tails = tails_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_snake_body_updater.sv
// tb/tb_snake_body_updater.sv - directed bench for snake_body_updater with a
// registered-read tail memory model.
module tb_snake_body_updater;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        grow;
  logic [11:0] cur_head_pos;
  logic [11:0] new_head_pos;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [6:0]  num_tails;
  logic        busy;
  logic        done;
  logic        collision;

  logic [11:0] mem [0:127];
  logic [6:0]  wa [0:127];
  logic [11:0] wd [0:127];
  int          wn;
  int          maxa;
  int          gmax;
  int          dc;
  int          tests;
  int          failed;
  int          lat;
  int          wsave;
  logic        coll;

  snake_body_updater #(.WORD_W(12), .ADDR_W(7), .MAX_TAILS(127)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .grow         (grow),
    .cur_head_pos (cur_head_pos),
    .new_head_pos (new_head_pos),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .num_tails    (num_tails),
    .busy         (busy),
    .done         (done),
    .collision    (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (done) dc = dc + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (wn < 128) begin
        wa[wn] = mem_addr;
        wd[wn] = mem_wdata;
      end
      wn = wn + 1;
      if (int'(mem_addr) > maxa) maxa = int'(mem_addr);
      if (int'(mem_addr) > gmax) gmax = int'(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are scrambled right after acceptance; the update must use the latched copies.
  task automatic run_update(input logic g, input logic [11:0] c, input logic [11:0] nw,
                            output int lt, output logic cl);
    @(negedge clk);
    tick = 1'b1; grow = g; cur_head_pos = c; new_head_pos = nw;
    @(negedge clk);
    tick = 1'b0; grow = ~g; cur_head_pos = ~c; new_head_pos = c;
    lt = 1;
    while (done !== 1'b1 && lt < 600) begin
      @(negedge clk);
      lt++;
    end
    cl = collision;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests = 0; failed = 0; wn = 0; maxa = 0; gmax = 0; dc = 0;
    for (int a = 0; a < 128; a++) mem[a] = '0;
    reset = 1'b1; tick = 1'b0; grow = 1'b0; cur_head_pos = '0; new_head_pos = '0;
    repeat (3) @(negedge clk);
    check("rst_num_tails", 32'(num_tails), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_collision", 32'(collision), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);

    // reset wins over a simultaneous tick
    tick = 1'b1; grow = 1'b1;
    @(negedge clk);
    tick = 1'b0; grow = 1'b0;
    check("rst_prio_busy", 32'(busy), 0);
    check("rst_prio_num", 32'(num_tails), 0);
    reset = 1'b0;
    @(negedge clk);

    // k=0: no memory access, immediate done, no collision even with cur==new
    wn = 0;
    run_update(1'b0, 12'h050, 12'h050, lat, coll);
    check("k0_latency", 32'(lat), 1);
    check("k0_writes", 32'(wn), 0);
    check("k0_collision", 32'(coll), 0);
    check("k0_num", 32'(num_tails), 0);

    // first growth
    wn = 0;
    run_update(1'b1, 12'h105, 12'h106, lat, coll);
    check("g1_latency", 32'(lat), 2);
    check("g1_writes", 32'(wn), 1);
    check("g1_addr", 32'(wa[0]), 0);
    check("g1_data", 32'(wd[0]), 32'h105);
    check("g1_collision", 32'(coll), 0);
    check("g1_num", 32'(num_tails), 1);

    // build body [104,103,102]
    do_reset();
    run_update(1'b1, 12'h102, 12'h103, lat, coll);
    run_update(1'b1, 12'h103, 12'h104, lat, coll);
    check("g2_latency", 32'(lat), 4);
    run_update(1'b1, 12'h104, 12'h105, lat, coll);
    check("g3_latency", 32'(lat), 6);
    check("g3_num", 32'(num_tails), 3);

    // plain move with n=3
    wn = 0;
    run_update(1'b0, 12'h105, 12'h106, lat, coll);
    check("mv_latency", 32'(lat), 6);
    check("mv_writes", 32'(wn), 3);
    check("mv_w0_addr", 32'(wa[0]), 2);
    check("mv_w0_data", 32'(wd[0]), 32'h103);
    check("mv_w1_addr", 32'(wa[1]), 1);
    check("mv_w1_data", 32'(wd[1]), 32'h104);
    check("mv_w2_addr", 32'(wa[2]), 0);
    check("mv_w2_data", 32'(wd[2]), 32'h105);
    check("mv_collision", 32'(coll), 0);
    check("mv_num", 32'(num_tails), 3);

    // body [105,104,103]: hit B collides, hit vacated C does not, hit head collides
    run_update(1'b0, 12'h106, 12'h104, lat, coll);
    check("coll_b", 32'(coll), 1);
    run_update(1'b0, 12'h107, 12'h104, lat, coll);
    check("coll_vacated_c", 32'(coll), 0);
    run_update(1'b0, 12'h108, 12'h108, lat, coll);
    check("coll_head", 32'(coll), 1);

    // ticks while busy and on the done cycle are dropped
    dc = 0;
    @(negedge clk);
    tick = 1'b1; grow = 1'b1; cur_head_pos = 12'h109; new_head_pos = 12'h10a;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    check("busy_tick_latency", 32'(lat), 8);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_tick_done_pulses", 32'(dc), 1);
    check("busy_tick_num", 32'(num_tails), 4);
    check("busy_tick_idle", 32'(busy), 0);

    // grow up to the limit, then grow once more at saturation
    for (int j = 4; j < 127; j++) begin
      run_update(1'b1, 12'h200 + 12'(j), 12'h300 + 12'(j), lat, coll);
    end
    check("fill_num", 32'(num_tails), 127);
    maxa = 0; wn = 0;
    run_update(1'b1, 12'h400, 12'h401, lat, coll);
    check("sat_latency", 32'(lat), 254);
    check("sat_num", 32'(num_tails), 127);
    check("sat_max_addr", 32'(maxa), 126);
    check("sat_writes", 32'(wn), 127);
    check("sat_collision", 32'(coll), 0);
    check("global_addr_bound", 32'(gmax > 126), 0);

    // reset in the 3rd cycle of an n=5 update
    do_reset();
    for (int j = 0; j < 5; j++) begin
      run_update(1'b1, 12'h500 + 12'(j), 12'h600 + 12'(j), lat, coll);
    end
    check("pre_abort_num", 32'(num_tails), 5);
    @(negedge clk);
    tick = 1'b1; grow = 1'b0; cur_head_pos = 12'h505; new_head_pos = 12'h606;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_num", 32'(num_tails), 0);
    wsave = wn;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_writes", 32'(wn), 32'(wsave));
    run_update(1'b1, 12'h700, 12'h701, lat, coll);
    check("post_abort_latency", 32'(lat), 2);
    check("post_abort_num", 32'(num_tails), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
